// File: rtl/icache_refill_ctrl.sv
// Icache miss/refill sequencer: stalls fetch on a tag miss, reads one line, writes it into the
// victim way, then pulses tag_refresh. Optional perf counters under `ifdef ICACHE_PERF_EN.
module icache_refill_ctrl #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int OFFSET_W   = 3,
  parameter int LINE_BEATS = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_flush,
  input  logic              i_tag_miss,
  input  logic              i_tag_lru,
  output logic              o_tag_refresh,
  output logic              o_tag_addr_sel,
  output logic [ADDR_W-1:0] o_miss_addr,
  output logic              o_stallreq,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_data_we,
  output logic [2:0]        o_data_beat,
  output logic [DATA_W-1:0] o_data_wdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       o_perf_hit,
  output logic [31:0]       o_perf_miss
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_REFILL, S_DRAIN} state_t;

  localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_miss_addr;
  logic              r_victim;
  logic [2:0]        r_beat;
  logic              w_miss, w_last, w_beat_inc;

  assign w_miss       = i_if_req & i_tag_miss & ~i_flush;
  assign w_last       = (r_beat == LAST_BEAT);
  assign o_miss_addr  = r_miss_addr;
  assign o_mem_addr   = r_miss_addr;
  assign o_data_wdata = i_mem_rdata;

  always_comb begin
    w_next         = r_state;
    w_beat_inc     = 1'b0;
    o_tag_refresh  = 1'b0;
    o_tag_addr_sel = 1'b0;
    o_stallreq     = 1'b0;
    o_mem_req      = 1'b0;
    o_data_we      = 2'b00;
    o_data_beat    = 3'd0;
    case (r_state)
      S_IDLE: begin
        o_stallreq = w_miss;
        if (w_miss) w_next = S_REQ;
      end
      S_REQ: begin
        o_mem_req      = 1'b1;
        o_stallreq     = 1'b1;
        o_tag_addr_sel = 1'b1;
        if (i_mem_gnt)    w_next = i_flush ? S_DRAIN : S_RECV;
        else if (i_flush) w_next = S_IDLE;
      end
      S_RECV: begin
        o_stallreq     = 1'b1;
        o_tag_addr_sel = 1'b1;
        o_data_beat    = r_beat;
        if (i_mem_rvalid) begin
          w_beat_inc = 1'b1;
          // A beat coinciding with flush is counted but not written.
          if (!i_flush) o_data_we = r_victim ? 2'b10 : 2'b01;
          if (w_last)       w_next = i_flush ? S_IDLE : S_REFILL;
          else if (i_flush) w_next = S_DRAIN;
        end else if (i_flush) begin
          w_next = S_DRAIN;
        end
      end
      S_REFILL: begin
        o_tag_refresh  = 1'b1;
        o_tag_addr_sel = 1'b1;
        o_stallreq     = 1'b1;
        w_next         = S_IDLE;
      end
      S_DRAIN: begin
        o_stallreq = 1'b1;
        if (i_mem_rvalid) begin
          w_beat_inc = 1'b1;
          if (w_last) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_miss_addr <= '0;
      r_victim    <= 1'b0;
      r_beat      <= 3'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_miss) begin
        r_miss_addr <= {i_if_addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
        r_victim    <= i_tag_lru;
      end
      if (r_state == S_REQ) r_beat <= 3'd0;
      else if (w_beat_inc)  r_beat <= r_beat + 3'd1;
    end
  end

`ifdef ICACHE_PERF_EN
  logic w_hit;
  assign w_hit = (r_state == S_IDLE) & i_if_req & ~i_tag_miss & ~i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_perf_hit  <= '0;
      o_perf_miss <= '0;
    end else begin
      if (w_hit && o_perf_hit != 32'hFFFF_FFFF)                       o_perf_hit  <= o_perf_hit + 32'd1;
      if (r_state == S_IDLE && w_miss && o_perf_miss != 32'hFFFF_FFFF) o_perf_miss <= o_perf_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl: a 1-beat and a 4-beat instance share stimulus;
// expected writes, refresh timing and addresses come from a line-level model.
module tb_icache_refill_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, flush, tag_miss, tag_lru, mem_gnt, mem_rvalid;
  logic [63:0] if_addr, mem_rdata;

  logic        d1_ref, d1_sel, d1_stall, d1_mreq, d4_ref, d4_sel, d4_stall, d4_mreq;
  logic [63:0] d1_maddr, d1_memaddr, d1_wdata, d4_maddr, d4_memaddr, d4_wdata;
  logic [1:0]  d1_we, d4_we;
  logic [2:0]  d1_beat, d4_beat;
`ifdef ICACHE_PERF_EN
  logic [31:0] d1_phit, d1_pmiss, d4_phit, d4_pmiss;
`endif

  icache_refill_ctrl #(.ADDR_W(64), .DATA_W(64), .OFFSET_W(3), .LINE_BEATS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_if_req(if_req), .i_if_addr(if_addr), .i_flush(flush),
    .i_tag_miss(tag_miss), .i_tag_lru(tag_lru), .o_tag_refresh(d1_ref), .o_tag_addr_sel(d1_sel),
    .o_miss_addr(d1_maddr), .o_stallreq(d1_stall), .o_mem_req(d1_mreq), .o_mem_addr(d1_memaddr),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_data_we(d1_we), .o_data_beat(d1_beat), .o_data_wdata(d1_wdata)
`ifdef ICACHE_PERF_EN
    , .o_perf_hit(d1_phit), .o_perf_miss(d1_pmiss)
`endif
  );

  icache_refill_ctrl #(.ADDR_W(64), .DATA_W(64), .OFFSET_W(5), .LINE_BEATS(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_if_req(if_req), .i_if_addr(if_addr), .i_flush(flush),
    .i_tag_miss(tag_miss), .i_tag_lru(tag_lru), .o_tag_refresh(d4_ref), .o_tag_addr_sel(d4_sel),
    .o_miss_addr(d4_maddr), .o_stallreq(d4_stall), .o_mem_req(d4_mreq), .o_mem_addr(d4_memaddr),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_data_we(d4_we), .o_data_beat(d4_beat), .o_data_wdata(d4_wdata)
`ifdef ICACHE_PERF_EN
    , .o_perf_hit(d4_phit), .o_perf_miss(d4_pmiss)
`endif
  );

  // Observed instance select: 0 = 1-beat, 1 = 4-beat.
  logic        sel4;
  logic        m_ref, m_sel, m_stall, m_mreq;
  logic [63:0] m_maddr, m_memaddr, m_wdata;
  logic [1:0]  m_we;
  logic [2:0]  m_beat;
  assign m_ref     = sel4 ? d4_ref     : d1_ref;
  assign m_sel     = sel4 ? d4_sel     : d1_sel;
  assign m_stall   = sel4 ? d4_stall   : d1_stall;
  assign m_mreq    = sel4 ? d4_mreq    : d1_mreq;
  assign m_maddr   = sel4 ? d4_maddr   : d1_maddr;
  assign m_memaddr = sel4 ? d4_memaddr : d1_memaddr;
  assign m_wdata   = sel4 ? d4_wdata   : d1_wdata;
  assign m_we      = sel4 ? d4_we      : d1_we;
  assign m_beat    = sel4 ? d4_beat    : d1_beat;

  typedef struct {logic [1:0] we; logic [2:0] beat; logic [63:0] data;} wr_t;
  wr_t         q_wr[$];
  int          q_ref[$];
  logic [63:0] q_memaddr[$];
  wr_t         mon_w;
  int          cyc = 0, last_stall, both_err, miss_cyc;
  int          checks = 0, failures = 0;
  logic [63:0] bd[8];

  always @(negedge clk) begin
    if (!rst) begin
      if (m_we != 2'b00) begin
        mon_w.we = m_we; mon_w.beat = m_beat; mon_w.data = m_wdata;
        q_wr.push_back(mon_w);
      end
      if (m_ref) q_ref.push_back(cyc);
      if (m_mreq) q_memaddr.push_back(m_memaddr);
      if (m_stall) last_stall = cyc;
      if (m_ref && m_we != 2'b00) both_err++;
    end
    cyc++;
  end

  task automatic step; @(posedge clk); #1; endtask

  task automatic idle_in;
    if_req = 0; flush = 0; tag_miss = 0; tag_lru = 0; mem_gnt = 0; mem_rvalid = 0;
    if_addr = '0; mem_rdata = '0;
  endtask

  task automatic clear_mon;
    q_wr.delete(); q_ref.delete(); q_memaddr.delete(); both_err = 0; last_stall = -1;
  endtask

  task automatic do_reset;
    idle_in; rst = 1; step; step; rst = 0; step;
  endtask

  // mode 0: clean refill; 1: flush in REQ at wait cycle k; 2: flush before beat k; 3: flush with gnt.
  task automatic drive_miss(input logic [63:0] addr, input logic lru, input int gntd,
                            input int mode, input int k, input int nb);
    clear_mon;
    if_req = 1; tag_miss = 1; if_addr = addr; tag_lru = lru; flush = 0; miss_cyc = cyc; step;
    if_req = 0; tag_miss = 0;
    for (int i = 0; i <= gntd; i++) begin
      tag_lru = 1'($urandom);
      if (mode == 1 && i == k) begin
        flush = 1; step; flush = 0; step; return;
      end
      mem_gnt = (i == gntd); flush = (mode == 3 && i == gntd); step;
    end
    mem_gnt = 0; flush = 0;
    for (int b = 0; b < nb; b++) begin
      if (mode == 2 && b == k) begin flush = 1; step; flush = 0; end
      mem_rvalid = 1; mem_rdata = bd[b]; tag_lru = 1'($urandom); step;
    end
    mem_rvalid = 0; step; step;
  endtask

  task automatic test_reset;
    idle_in; rst = 1; #2;
    checks++; if ({d1_ref, d1_sel, d1_stall, d1_mreq, d1_we, d1_beat} !== 9'd0) begin
      failures++; $display("FAIL reset_ctrl_d1 got=%b want=0", {d1_ref, d1_sel, d1_stall, d1_mreq, d1_we, d1_beat}); end
    checks++; if ({d4_ref, d4_sel, d4_stall, d4_mreq, d4_we, d4_beat} !== 9'd0) begin
      failures++; $display("FAIL reset_ctrl_d4 got=%b want=0", {d4_ref, d4_sel, d4_stall, d4_mreq, d4_we, d4_beat}); end
    checks++; if (d1_maddr !== 64'd0 || d4_maddr !== 64'd0 || d1_memaddr !== 64'd0) begin
      failures++; $display("FAIL reset_addr got=%h/%h want=0", d1_maddr, d4_maddr); end
    step; rst = 0; step;
  endtask

  task automatic test_hit;
    sel4 = 0; clear_mon;
    for (int i = 0; i < 10; i++) begin
      if_req = 1; tag_miss = 0; if_addr = {$urandom, $urandom}; #1;
      checks++; if ({m_stall, m_mreq, m_ref} !== 3'b000) begin
        failures++; $display("FAIL hit_nostall cyc%0d got=%b want=000", i, {m_stall, m_mreq, m_ref}); end
      step;
    end
    idle_in; step;
    checks++; if (q_memaddr.size() != 0 || q_ref.size() != 0) begin
      failures++; $display("FAIL hit_traffic got=%0d/%0d want=0/0", q_memaddr.size(), q_ref.size()); end
  endtask

  // Compares one transaction's observations against the line-level model.
  task automatic test_miss_txn(input string nm, input logic [63:0] addr, input logic lru,
                               input int gntd, input int mode, input int k, input int nb);
    logic [63:0] line;
    int          exp_wr, exp_ref, exp_req;
    line = (addr / 64'(nb * 8)) * 64'(nb * 8);
    drive_miss(addr, lru, gntd, mode, k, nb);
    exp_wr  = (mode == 0) ? nb : (mode == 2) ? k : 0;
    exp_ref = (mode == 0) ? 1 : 0;
    exp_req = (mode == 1) ? k + 1 : gntd + 1;
    checks++; if (q_wr.size() != exp_wr) begin
      failures++; $display("FAIL %s wr_count got=%0d want=%0d", nm, q_wr.size(), exp_wr); end
    for (int b = 0; b < exp_wr && b < q_wr.size(); b++) begin
      checks++;
      if (q_wr[b].we !== (lru ? 2'b10 : 2'b01) || q_wr[b].beat !== 3'(b) || q_wr[b].data !== bd[b]) begin
        failures++; $display("FAIL %s wr%0d got=%b/%0d/%h want=%b/%0d/%h", nm, b, q_wr[b].we,
          q_wr[b].beat, q_wr[b].data, lru ? 2'b10 : 2'b01, b, bd[b]); end
    end
    checks++; if (q_ref.size() != exp_ref) begin
      failures++; $display("FAIL %s refresh_count got=%0d want=%0d", nm, q_ref.size(), exp_ref); end
    if (exp_ref == 1 && q_ref.size() == 1) begin
      checks++; if (q_ref[0] - miss_cyc != 2 + gntd + nb) begin
        failures++; $display("FAIL %s latency got=%0d want=%0d", nm, q_ref[0] - miss_cyc, 2 + gntd + nb); end
      checks++; if (last_stall != q_ref[0]) begin
        failures++; $display("FAIL %s stall_release got=%0d want=%0d", nm, last_stall, q_ref[0]); end
    end
    checks++; if (q_memaddr.size() != exp_req) begin
      failures++; $display("FAIL %s req_cycles got=%0d want=%0d", nm, q_memaddr.size(), exp_req); end
    foreach (q_memaddr[i]) if (q_memaddr[i] !== line) begin
      checks++; failures++; $display("FAIL %s mem_addr got=%h want=%h", nm, q_memaddr[i], line); break; end
    checks++; if (m_maddr !== line) begin
      failures++; $display("FAIL %s miss_addr got=%h want=%h", nm, m_maddr, line); end
    checks++; if ({m_stall, m_mreq, m_ref, m_we} !== 5'd0 || both_err != 0) begin
      failures++; $display("FAIL %s end_idle got=%b both=%0d want=0", nm, {m_stall, m_mreq, m_ref, m_we}, both_err); end
  endtask

  task automatic test_directed;
    sel4 = 0; bd[0] = 64'hDEAD_BEEF_0000_0013;
    test_miss_txn("miss_1beat", 64'h8000_0014, 1'b1, 3, 0, 0, 1);
    test_miss_txn("flush_req", 64'h0000_1238, 1'b0, 4, 1, 2, 1);
    do_reset; sel4 = 1;
    for (int b = 0; b < 4; b++) bd[b] = {$urandom, $urandom};
    test_miss_txn("flush_recv", 64'h0004_5678, 1'b0, 1, 2, 2, 4);
    do_reset;
    test_miss_txn("flush_gnt", 64'h0000_0040, 1'b1, 0, 3, 0, 4);
  endtask

  task automatic test_reset_recv;
    do_reset; sel4 = 1; clear_mon;
    if_req = 1; tag_miss = 1; if_addr = 64'h1234_5660; step;
    if_req = 0; tag_miss = 0; mem_gnt = 1; step;
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'h1111; step;
    mem_rdata = 64'h2222; #2; rst = 1; #1;
    checks++; if ({m_ref, m_sel, m_stall, m_mreq, m_we, m_beat} !== 9'd0 || m_maddr !== 64'd0) begin
      failures++; $display("FAIL rst_recv_outputs got=%b/%h want=0", {m_ref, m_sel, m_stall, m_mreq, m_we, m_beat}, m_maddr); end
    step; rst = 0; mem_rdata = 64'h3333; step; step; mem_rvalid = 0; step;
    checks++; if (q_wr.size() != 1 || q_memaddr.size() != 1) begin
      failures++; $display("FAIL rst_recv_stray got=%0d/%0d want=1/1", q_wr.size(), q_memaddr.size()); end
  endtask

  task automatic test_random;
    int nb, mode, k, gntd;
    for (int t = 0; t < 24; t++) begin
      do_reset;
      sel4 = 1'(t & 1); nb = sel4 ? 4 : 1;
      for (int b = 0; b < 8; b++) bd[b] = {$urandom, $urandom};
      gntd = $urandom_range(0, 4); mode = $urandom_range(0, 3); k = 0;
      if (mode == 1) k = $urandom_range(0, gntd);
      if (mode == 2) begin if (nb == 1) mode = 0; else k = $urandom_range(1, nb - 1); end
      test_miss_txn($sformatf("rand%0d_m%0d", t, mode), {$urandom, $urandom}, 1'($urandom), gntd, mode, k, nb);
    end
  endtask

  task automatic test_back_to_back;
    do_reset; sel4 = 1;
    for (int b = 0; b < 4; b++) bd[b] = {$urandom, $urandom};
    test_miss_txn("b2b_a", 64'hA000_0000, 1'b0, 0, 0, 0, 4);
    test_miss_txn("b2b_b", 64'hA000_0020, 1'b1, 2, 0, 0, 4);
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf;
    do_reset; sel4 = 0; bd[0] = 64'h55;
    for (int i = 0; i < 5; i++) begin if_req = 1; tag_miss = 0; if_addr = 64'(i * 8); step; end
    idle_in; step;
    drive_miss(64'h100, 1'b0, 0, 0, 0, 1);
    drive_miss(64'h208, 1'b1, 1, 0, 0, 1);
    checks++; if (d1_phit !== 32'd5 || d1_pmiss !== 32'd2) begin
      failures++; $display("FAIL perf_counts got=%0d/%0d want=5/2", d1_phit, d1_pmiss); end
  endtask
`endif

  initial begin
    idle_in; rst = 0; sel4 = 0; last_stall = -1; both_err = 0; miss_cyc = 0;
    #1;
    test_reset;
    test_hit;
    test_directed;
    test_reset_recv;
    test_back_to_back;
    test_random;
`ifdef ICACHE_PERF_EN
    test_perf;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
